nco_phase_accumulator: RTL and testbench

- Numerically-controlled-oscillator phase generator that sits directly upstream of the sintable lookup.
- Drives sintable's 8-bit phase input (i_data) from a wide accumulator, truncated to PHASE_WIDTH bits.
- Provides programmable frequency, phase offset, phase-continuous frequency retuning and a phase sync.
- Advances once per sample strobe, so the sine table is clocked at the DSP sample rate, not the system clock.

---
 rtl/nco_pkg.sv | 22 ++
 rtl/nco_freq_reg.sv | 60 ++++++
 rtl/nco_phase_accumulator.sv | 103 ++++++++++
 tb/tb_nco_phase_accumulator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared NCO definitions: default widths, run-state encoding and phase-truncation helper.
// Pure declarations; no latency and no flow control.
package nco_pkg;

  localparam int NCO_ACC_WIDTH   = 24;
  localparam int NCO_PHASE_WIDTH = 8;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } nco_state_e;

  // Top ph_w bits of an acc_w-bit accumulator, right-aligned in a 64-bit result.
  function automatic logic [63:0] phase_slice(input logic [63:0] acc,
                                              input int          acc_w,
                                              input int          ph_w);
    logic [63:0] mask;
    mask = (64'd1 << ph_w) - 64'd1;
    return (acc >> (acc_w - ph_w)) & mask;
  endfunction

endpackage

// File: rtl/nco_freq_reg.sv
// Pending/active tuning-word pair with immediate or at-wrap handover; o_inc is combinational.
// Handover lands on the edge of the accepted step that triggers it; no backpressure.
module nco_freq_reg
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH = NCO_ACC_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_freq_wr,
  input  logic [ACC_WIDTH-1:0] i_freq,
  input  logic                 i_freq_at_wrap,
  input  logic                 i_step,
  input  logic                 i_carry,
  output logic [ACC_WIDTH-1:0] o_inc,
  output logic                 o_freq_pending
);

  logic [ACC_WIDTH-1:0] active_q, active_d;
  logic [ACC_WIDTH-1:0] pend_word_q, pend_word_d;
  logic                 pend_q, pend_d;
  logic                 at_wrap_q, at_wrap_d;
  logic                 xfer;

  // An immediate-mode word is already used by the step that hands it over.
  assign o_inc          = (pend_q && !at_wrap_q) ? pend_word_q : active_q;
  assign xfer           = pend_q && i_step && (!at_wrap_q || i_carry);
  assign o_freq_pending = pend_q;

  always_comb begin
    active_d    = active_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    at_wrap_d   = at_wrap_q;
    if (xfer) begin
      active_d = pend_word_q;
      pend_d   = 1'b0;
    end
    if (i_freq_wr) begin
      pend_word_d = i_freq;
      at_wrap_d   = i_freq_at_wrap;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active_q    <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      at_wrap_q   <= 1'b0;
    end else begin
      active_q    <= active_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      at_wrap_q   <= at_wrap_d;
    end
  end

endmodule

// File: rtl/nco_phase_accumulator.sv
// NCO phase generator for the sine table: one accumulation per accepted sample strobe.
// One cycle from i_ce to o_valid; no backpressure, the consumer must take every pulse.
module nco_phase_accumulator
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH   = NCO_ACC_WIDTH,
  parameter int PHASE_WIDTH = NCO_PHASE_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_ce,
  input  logic                   i_freq_wr,
  input  logic [ACC_WIDTH-1:0]   i_freq,
  input  logic                   i_freq_at_wrap,
  input  logic                   i_offset_wr,
  input  logic [PHASE_WIDTH-1:0] i_offset,
  input  logic                   i_sync,
  output logic [PHASE_WIDTH-1:0] o_phase,
  output logic                   o_valid,
  output logic                   o_wrap,
  output logic                   o_freq_pending
);

  nco_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] offset_q, offset_d;
  logic                   valid_q, valid_d;
  logic                   wrap_q, wrap_d;

  logic                   accept;
  logic                   step;
  logic [ACC_WIDTH-1:0]   inc;
  logic [ACC_WIDTH:0]     sum;
  logic [63:0]            slice_full;
  logic [PHASE_WIDTH-1:0] phase_next;

  assign accept     = (state_q == ST_RUNNING) && i_ce;
  // Sync pre-empts accumulation, so such a cycle is not a step for the tuning-word logic.
  assign step       = accept && !i_sync;
  assign sum        = {1'b0, acc_q} + {1'b0, inc};
  assign slice_full = phase_slice(64'(sum[ACC_WIDTH-1:0]), ACC_WIDTH, PHASE_WIDTH);
  assign phase_next = slice_full[PHASE_WIDTH-1:0] + offset_q;

  nco_freq_reg #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_freq_reg (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_freq_wr      (i_freq_wr),
    .i_freq         (i_freq),
    .i_freq_at_wrap (i_freq_at_wrap),
    .i_step         (step),
    .i_carry        (sum[ACC_WIDTH]),
    .o_inc          (inc),
    .o_freq_pending (o_freq_pending)
  );

  always_comb begin
    state_d  = i_enable ? ST_RUNNING : ST_STOPPED;
    offset_d = i_offset_wr ? i_offset : offset_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    if (i_sync) begin
      acc_d = '0;
      if (accept) begin
        phase_d = offset_q;
        valid_d = 1'b1;
      end
    end else if (accept) begin
      acc_d   = sum[ACC_WIDTH-1:0];
      phase_d = phase_next;
      valid_d = 1'b1;
      wrap_d  = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_STOPPED;
      acc_q    <= '0;
      phase_q  <= '0;
      offset_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_phase = phase_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Scoreboard bench for nco_phase_accumulator at ACC_WIDTH=16, PHASE_WIDTH=8.
module tb_nco_phase_accumulator;

  localparam int AW = 16;
  localparam int PW = 8;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_ce = 1'b0;
  logic          i_freq_wr = 1'b0;
  logic [AW-1:0] i_freq = '0;
  logic          i_freq_at_wrap = 1'b0;
  logic          i_offset_wr = 1'b0;
  logic [PW-1:0] i_offset = '0;
  logic          i_sync = 1'b0;
  logic [PW-1:0] o_phase;
  logic          o_valid;
  logic          o_wrap;
  logic          o_freq_pending;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  nco_phase_accumulator #(
    .ACC_WIDTH  (AW),
    .PHASE_WIDTH(PW)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_enable       (i_enable),
    .i_ce           (i_ce),
    .i_freq_wr      (i_freq_wr),
    .i_freq         (i_freq),
    .i_freq_at_wrap (i_freq_at_wrap),
    .i_offset_wr    (i_offset_wr),
    .i_offset       (i_offset),
    .i_sync         (i_sync),
    .o_phase        (o_phase),
    .o_valid        (o_valid),
    .o_wrap         (o_wrap),
    .o_freq_pending (o_freq_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_ce        = 1'b0;
    i_freq_wr   = 1'b0;
    i_offset_wr = 1'b0;
    i_sync      = 1'b0;
  endtask

  task automatic step(input logic [7:0] ph, input logic w);
    exp_q.push_back({w, ph});
    i_ce = 1'b1;
    tick();
  endtask

  task automatic wrfreq(input logic [AW-1:0] f, input logic aw);
    i_freq         = f;
    i_freq_at_wrap = aw;
    i_freq_wr      = 1'b1;
    tick();
  endtask

  // Monitor: every valid output is matched against the oldest expected entry.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(o_phase), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("phase", 32'(o_phase), 32'(e[7:0]));
          chk("wrap", 32'(o_wrap), 32'(e[8]));
        end
      end else if (o_wrap !== 1'b0) begin
        chk("wrap_without_valid", 32'(o_wrap), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_phase", 32'(o_phase), 32'h00);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_wrap", 32'(o_wrap), 32'd0);
    chk("rst_pend", 32'(o_freq_pending), 32'd0);
    i_reset_n = 1'b1;

    // Stopped: strobes are ignored.
    for (int i = 0; i < 6; i++) begin
      i_ce = 1'(i % 2);
      tick();
      chk("t1_phase", 32'(o_phase), 32'h00);
      chk("t1_valid", 32'(o_valid), 32'd0);
    end

    // Full phase cycle at +1 per step.
    i_enable = 1'b1;
    wrfreq(16'h0100, 1'b0);
    chk("t2_pend", 32'(o_freq_pending), 32'd1);
    for (int i = 0; i < 256; i++) step(8'(i + 1), (i == 255));
    chk("t2_pend_clr", 32'(o_freq_pending), 32'd0);

    // Retune at wrap from acc=0x8000.
    for (int i = 0; i < 128; i++) step(8'(i + 1), 1'b0);
    wrfreq(16'h0400, 1'b1);
    chk("t3_pend", 32'(o_freq_pending), 32'd1);
    for (int i = 0; i < 127; i++) step(8'(8'h81 + i), 1'b0);
    chk("t3_pend_pre_wrap", 32'(o_freq_pending), 32'd1);
    step(8'h00, 1'b1);
    chk("t3_pend_post_wrap", 32'(o_freq_pending), 32'd0);
    step(8'h04, 1'b0);
    step(8'h08, 1'b0);
    step(8'h0C, 1'b0);

    // Immediate retune, then last-write-wins.
    wrfreq(16'h0100, 1'b0);
    step(8'h0D, 1'b0);
    chk("t4_pend_a", 32'(o_freq_pending), 32'd0);
    wrfreq(16'h0400, 1'b0);
    chk("t4_pend_b", 32'(o_freq_pending), 32'd1);
    step(8'h11, 1'b0);
    chk("t4_pend_c", 32'(o_freq_pending), 32'd0);
    step(8'h15, 1'b0);
    wrfreq(16'h0300, 1'b1);
    wrfreq(16'h0100, 1'b0);
    step(8'h16, 1'b0);
    chk("t4_pend_d", 32'(o_freq_pending), 32'd0);

    // Sync without strobe, offset, sync with strobe.
    i_sync = 1'b1;
    tick();
    chk("t5_sync_hold", 32'(o_phase), 32'h16);
    for (int i = 0; i < 16; i++) step(8'(i + 1), 1'b0);
    i_offset    = 8'h40;
    i_offset_wr = 1'b1;
    tick();
    step(8'h51, 1'b0);
    i_sync = 1'b1;
    step(8'h40, 1'b0);
    step(8'h41, 1'b0);

    // Zero tuning word, then write landing on a handover cycle.
    wrfreq(16'h0000, 1'b0);
    step(8'h41, 1'b0);
    step(8'h41, 1'b0);
    wrfreq(16'h0100, 1'b0);
    i_freq    = 16'h0200;
    i_freq_wr = 1'b1;
    step(8'h42, 1'b0);
    chk("t5_pend_overlap", 32'(o_freq_pending), 32'd1);
    step(8'h44, 1'b0);
    chk("t5_pend_overlap_clr", 32'(o_freq_pending), 32'd0);

    // Asynchronous reset with a word pending.
    wrfreq(16'h0400, 1'b1);
    chk("t6_pend", 32'(o_freq_pending), 32'd1);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("t6_phase", 32'(o_phase), 32'h00);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_pend_rst", 32'(o_freq_pending), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    wrfreq(16'h0200, 1'b0);
    step(8'h02, 1'b0);
    step(8'h04, 1'b0);
    step(8'h06, 1'b0);
    step(8'h08, 1'b0);

    i_enable = 1'b0;
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
